ones_frame_accum: RTL
=====================

// Module: ones_frame_accum
// PURPOSE
//  Downstream consumer of the 8-bit combinational popcount (counter1s).
//  Accepts a byte stream framed by in_last over a valid/ready handshake and
//  sums the ones count of every byte in the frame.
//  Presents the frame total, byte count and status flags on a valid/ready
//  output.
//  Sits between the byte source and the frame-statistics sink.
// PARAMETERS
//  MAX_BYTES  255  bytes per frame before forced termination (1..255)
//  CNT_W      11   accumulator/output width; 11 covers 8*255=2040 without saturation
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_data    in   8      byte to count
//  in_valid   in   1      in_data/in_last valid
//  in_last    in   1      final byte of frame
//  in_ready   out  1      block accepts a byte this cycle
//  out_count  out  CNT_W  total ones in frame
//  out_bytes  out  8      number of bytes accepted in frame
//  out_sat    out  1      accumulator saturated during frame
//  out_trunc  out  1      frame forcibly ended at MAX_BYTES (in_last absent)
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      sink accepts result
// BEHAVIOUR
//  Reset
//   - rst_n low asynchronously forces state=ACC, acc=0, byte_cnt=0.
//   - All out_* = 0 during reset; in_ready=1 once rst_n deasserts.
//   - Reset mid-frame or mid-HOLD discards all partial or pending results.
//  States (2)
//   - ACC:  in_ready=1, out_valid=0.
//   - HOLD: in_ready=0, out_valid=1, outputs stable.
//  Byte acceptance in ACC (accept = in_valid & in_ready)
//   - acc <= sat(acc + pop(in_data)); byte_cnt <= byte_cnt+1.
//   - pop() is the popcount of in_data, computed combinationally in the same
//     cycle it is accepted.
//  Frame end = accept & (in_last | byte_cnt+1 == MAX_BYTES)
//   - out_count <= sat(acc+pop); out_bytes <= byte_cnt+1.
//   - out_trunc <= ~in_last; out_sat <= sat flag including this byte.
//   - acc, byte_cnt, sat flag cleared; go to HOLD.
//   - out_valid rises the cycle after the last accepted byte (latency 1).
//  HOLD
//   - out_valid & out_ready -> ACC next cycle, out_valid=0.
//   - One bubble: no byte is accepted in the handshake cycle.
//   - out_ready low holds every output unchanged indefinitely.
//  Saturation
//   - Sum clamps at 2^CNT_W-1 and sets the sticky sat flag for the frame.
//  Input rules
//   - in_valid with in_ready=0 is ignored; the source must hold data.
//   - in_last with in_valid=0 is ignored.
//  Single-byte frame (in_last on first byte) is legal: out_bytes=1.
//  Truncation
//   - After a truncated frame the next accepted byte starts a new frame.
//   - No bytes are dropped.
// STRUCTURE
//  - Package counter_pkg: state encodings ACC=1'b0, HOLD=1'b1.
//  - counter_pkg also holds localparam POP_W=4 and the default CNT_W.
//  - Sub-module: one instance of existing counter1s (in[7:0] -> y[3:0]) on
//    in_data.
//  - Everything else (FSM, accumulator, saturation logic) lives in this
//    module.
//  - Elaboration check: MAX_BYTES in 1..255, CNT_W >= 4.
// TESTING
//  1 Reset then frame {8'hFF,8'h0F,8'h01 last}
//    -> out_count=13, out_bytes=3, sat=0, trunc=0, out_valid 1 cycle after
//       the last byte.
//  2 Single byte 8'hA5 with in_last, out_ready held low 5 cycles
//    -> out_count=4, out_bytes=1 stable throughout; in_ready=0 until the
//       handshake, then 1 on the next cycle.
//  3 MAX_BYTES=4, six bytes of 8'h01, no in_last
//    -> first result count=4, bytes=4, trunc=1.
//    -> 2nd frame starts at byte 5; in_last on byte 6 gives count=2,
//       bytes=2, trunc=0.
//  4 CNT_W=4, frame of three 8'hFF
//    -> out_count=15, out_sat=1; next frame {8'h03 last} gives count=2,
//       sat=0.
//  5 rst_n pulsed low mid-frame after 2 bytes, then {8'h80 last}
//    -> out_count=1, out_bytes=1; outputs 0 asynchronously during reset.
//  6 in_valid toggling randomly with gaps, frame 8'h00..8'h07
//    -> out_count=12, out_bytes=8; no byte lost or double-counted.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings and widths for the ones-count frame accumulator.
package counter_pkg;
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int POP_W     = 4;
  localparam int CNT_W_DEF = 11;
endpackage

// File: rtl/counter1s.sv
// Combinational popcount of one byte.
module counter1s (
  input  logic [7:0] in,
  output logic [3:0] y
);
  always_comb begin
    y = '0;
    for (int i = 0; i < 8; i++) begin
      y = y + {3'b000, in[i]};
    end
  end
endmodule

// File: rtl/ones_frame_accum.sv
// Sums byte popcounts over an in_last-framed stream and presents per-frame
// totals, byte count and saturation/truncation flags on a valid/ready output.
module ones_frame_accum
  import counter_pkg::*;
#(
  parameter int MAX_BYTES = 255,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [CNT_W-1:0] out_count,
  output logic [7:0]       out_bytes,
  output logic             out_sat,
  output logic             out_trunc,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  if (MAX_BYTES < 1 || MAX_BYTES > 255 || CNT_W < 4) begin : g_param_check
    $error("ones_frame_accum: MAX_BYTES must be 1..255 and CNT_W >= 4");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic [7:0]       out_bytes_q, out_bytes_d;
  logic             out_sat_q, out_sat_d;
  logic             out_trunc_q, out_trunc_d;

  logic [POP_W-1:0] pop;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] sum_clamped;
  logic             sat_now;
  logic [8:0]       cnt_inc;
  logic             accept;
  logic             frame_end;

  counter1s u_pop (
    .in (in_data),
    .y  (pop)
  );

  always_comb begin
    // One extra bit catches the carry that signals saturation.
    sum         = {1'b0, acc_q} + {{(CNT_W + 1 - POP_W){1'b0}}, pop};
    sum_clamped = sum[CNT_W] ? CMAX : sum[CNT_W-1:0];
    sat_now     = sat_q | sum[CNT_W];
    cnt_inc     = {1'b0, byte_cnt_q} + 9'd1;
    accept      = in_valid & (state_q == ACC);
    frame_end   = accept & (in_last | (cnt_inc == 9'(MAX_BYTES)));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    byte_cnt_d  = byte_cnt_q;
    sat_d       = sat_q;
    out_count_d = out_count_q;
    out_bytes_d = out_bytes_q;
    out_sat_d   = out_sat_q;
    out_trunc_d = out_trunc_q;
    case (state_q)
      ACC: begin
        if (frame_end) begin
          out_count_d = sum_clamped;
          out_bytes_d = cnt_inc[7:0];
          out_sat_d   = sat_now;
          out_trunc_d = ~in_last;
          acc_d       = '0;
          byte_cnt_d  = '0;
          sat_d       = 1'b0;
          state_d     = HOLD;
        end else if (accept) begin
          acc_d      = sum_clamped;
          byte_cnt_d = cnt_inc[7:0];
          sat_d      = sat_now;
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      byte_cnt_q  <= '0;
      sat_q       <= 1'b0;
      out_count_q <= '0;
      out_bytes_q <= '0;
      out_sat_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      byte_cnt_q  <= byte_cnt_d;
      sat_q       <= sat_d;
      out_count_q <= out_count_d;
      out_bytes_q <= out_bytes_d;
      out_sat_q   <= out_sat_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_count = out_count_q;
  assign out_bytes = out_bytes_q;
  assign out_sat   = out_sat_q;
  assign out_trunc = out_trunc_q;
endmodule
